hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 16 +
 rtl/hazard_scoreboard_if.sv | 42 ++++
 rtl/hazard_scoreboard_fwd_port_mux.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 137 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the hazard scoreboard.
package sb_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 32;
  localparam int DEFAULT_XLEN  = 32;

  // Hazard classification reported by each read-port mux.
  typedef enum logic [1:0] {
    NONE     = 2'd0,
    LOAD_USE = 2'd1,
    LONG_RAW = 2'd2,
    WAW      = 2'd3
  } hazard_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: read ports, pipeline stage
// snapshots, issue and long-op completion inputs, bypass/stall outputs.
interface hazard_scoreboard_if #(
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_STAGES   = 4,
  parameter int XLEN         = 32
);

  logic [NUM_RD_PORTS-1:0][4:0]      rs_addr;
  logic [NUM_STAGES-1:0]             stg_wen;
  logic [NUM_STAGES-1:0][4:0]        stg_rd;
  logic [NUM_STAGES-1:0][XLEN-1:0]   stg_data;
  logic [NUM_STAGES-1:0]             stg_data_ok;
  logic                              issue_valid;
  logic                              issue_long;
  logic [4:0]                        issue_rd;
  logic                              lc_valid;
  logic [4:0]                        lc_rd;
  logic [XLEN-1:0]                   lc_data;
  logic [NUM_RD_PORTS-1:0]           fwd_sel;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0] fwd_data;
  logic                              stall;
  logic [31:0]                       stall_cnt;
  logic                              wdog_err;

  // Decode / pipeline side
  modport master (
    output rs_addr, stg_wen, stg_rd, stg_data, stg_data_ok,
    output issue_valid, issue_long, issue_rd,
    output lc_valid, lc_rd, lc_data,
    input  fwd_sel, fwd_data, stall, stall_cnt, wdog_err
  );

  // Scoreboard side
  modport slave (
    input  rs_addr, stg_wen, stg_rd, stg_data, stg_data_ok,
    input  issue_valid, issue_long, issue_rd,
    input  lc_valid, lc_rd, lc_data,
    output fwd_sel, fwd_data, stall, stall_cnt, wdog_err
  );

endinterface

// File: rtl/hazard_scoreboard_fwd_port_mux.sv
// One decode read port: youngest-stage priority search, then long-op
// busy check with same-cycle completion bypass.
module fwd_port_mux
  import sb_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int XLEN       = DEFAULT_XLEN
) (
  input  logic [REG_ADDR_W-1:0]                 rs,
  input  logic [NUM_STAGES-1:0]                 stg_wen,
  input  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] stg_rd,
  input  logic [NUM_STAGES-1:0][XLEN-1:0]       stg_data,
  input  logic [NUM_STAGES-1:0]                 stg_data_ok,
  input  logic [NUM_ARCH_REGS-1:0]              busy,
  input  logic                                  lc_valid,
  input  logic [REG_ADDR_W-1:0]                 lc_rd,
  input  logic [XLEN-1:0]                       lc_data,
  output logic                                  sel,
  output logic [XLEN-1:0]                       data,
  output hazard_e                               hazard
);

  logic stg_hit;

  // Lowest index wins; a not-yet-ready youngest producer masks older ready ones.
  always_comb begin
    sel     = 1'b0;
    data    = '0;
    hazard  = NONE;
    stg_hit = 1'b0;
    if (rs != '0) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (!stg_hit && stg_wen[i] && (stg_rd[i] == rs)) begin
          stg_hit = 1'b1;
          if (stg_data_ok[i]) begin
            sel  = 1'b1;
            data = stg_data[i];
          end else begin
            hazard = LOAD_USE;
          end
        end
      end
      if (!stg_hit && busy[rs]) begin
        if (lc_valid && (lc_rd == rs)) begin
          sel  = 1'b1;
          data = lc_data;
        end else begin
          hazard = LONG_RAW;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode hazard scoreboard: per-port bypass selection, long-op busy
// tracking, stall generation and a saturating stall counter.
// Optional consecutive-stall watchdog enabled by defining SB_WDOG_EN.
module hazard_scoreboard
  import sb_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_STAGES   = 4,
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int STALL_LIMIT  = 1023
) (
  input logic              clk,
  input logic              rst,
  hazard_scoreboard_if.slave sb
);

  localparam logic [31:0] LIMIT = 32'(STALL_LIMIT);

  logic [NUM_ARCH_REGS-1:0] busy_q, busy_d;
  logic [NUM_ARCH_REGS-1:0] busy_eff;
  logic [31:0]              stall_cnt_q, stall_cnt_d;
  logic                     wdog_err_q, wdog_err_d;
  logic [NUM_RD_PORTS-1:0]  port_raw;
  hazard_e                  port_hz [NUM_RD_PORTS];
  logic                     waw;
  logic                     stall;

  // While reset is asserted only stage forwarding may act.
  always_comb begin
    busy_eff = rst ? '0 : busy_q;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_port_mux #(
      .NUM_STAGES (NUM_STAGES),
      .XLEN       (XLEN)
    ) u_mux (
      .rs          (sb.rs_addr[p]),
      .stg_wen     (sb.stg_wen),
      .stg_rd      (sb.stg_rd),
      .stg_data    (sb.stg_data),
      .stg_data_ok (sb.stg_data_ok),
      .busy        (busy_eff),
      .lc_valid    (sb.lc_valid),
      .lc_rd       (sb.lc_rd),
      .lc_data     (sb.lc_data),
      .sel         (sb.fwd_sel[p]),
      .data        (sb.fwd_data[p]),
      .hazard      (port_hz[p])
    );
  end

  // Combine port RAW hazards with the issue-side WAW check into stall.
  always_comb begin
    port_raw = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      port_raw[p] = (port_hz[p] != NONE);
    end
    waw = sb.issue_valid && (sb.issue_rd != '0) && busy_eff[sb.issue_rd] &&
          !(sb.lc_valid && (sb.lc_rd == sb.issue_rd));
    stall = (|port_raw) || waw;
  end

  // Busy update: clear on completion first so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (sb.lc_valid) begin
      busy_d[sb.lc_rd] = 1'b0;
    end
    if (sb.issue_valid && sb.issue_long && (sb.issue_rd != '0) && !stall) begin
      busy_d[sb.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

`ifdef SB_WDOG_EN
  logic [31:0] wdog_cnt_q, wdog_cnt_d;

  // Consecutive-stall counter; error latches once the run reaches LIMIT.
  always_comb begin
    wdog_cnt_d = '0;
    wdog_err_d = wdog_err_q;
    if (stall) begin
      wdog_cnt_d = (wdog_cnt_q < LIMIT) ? (wdog_cnt_q + 32'd1) : wdog_cnt_q;
      if ((wdog_cnt_q < LIMIT) && ((wdog_cnt_q + 32'd1) >= LIMIT)) begin
        wdog_err_d = 1'b1;
      end
      if (wdog_cnt_q >= LIMIT) begin
        wdog_err_d = 1'b1;
      end
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end
`else
  logic unused_limit;

  // Watchdog absent: error held low.
  always_comb begin
    wdog_err_d   = 1'b0;
    unused_limit = ^LIMIT;
  end
`endif

  // Scoreboard state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
      wdog_err_q  <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      wdog_err_q  <= wdog_err_d;
    end
  end

  assign sb.stall     = stall;
  assign sb.stall_cnt = stall_cnt_q;
  assign sb.wdog_err  = wdog_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; watchdog expectations follow SB_WDOG_EN.
module tb_hazard_scoreboard;

`ifdef SB_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hazard_scoreboard_if #(.NUM_RD_PORTS(2), .NUM_STAGES(4), .XLEN(32)) sb_if ();

  hazard_scoreboard #(
    .NUM_RD_PORTS (2),
    .NUM_STAGES   (4),
    .XLEN         (32),
    .STALL_LIMIT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb_if.rs_addr     = '0;
    sb_if.stg_wen     = '0;
    sb_if.stg_rd      = '0;
    sb_if.stg_data    = '0;
    sb_if.stg_data_ok = '0;
    sb_if.issue_valid = 1'b0;
    sb_if.issue_long  = 1'b0;
    sb_if.issue_rd    = '0;
    sb_if.lc_valid    = 1'b0;
    sb_if.lc_rd       = '0;
    sb_if.lc_data     = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    // forwarding still works during reset
    sb_if.stg_wen[0] = 1'b1; sb_if.stg_rd[0] = 5'd5;
    sb_if.stg_data[0] = 32'h55; sb_if.stg_data_ok[0] = 1'b1;
    sb_if.rs_addr[0] = 5'd5;
    #2;
    chk("rst_fwd_sel", 64'(sb_if.fwd_sel[0]), 64'd1);
    chk("rst_fwd_data", 64'(sb_if.fwd_data[0]), 64'h55);
    cyc();
    rst = 1'b0;
    idle();
    #2;
    chk("reset_stall_cnt", 64'(sb_if.stall_cnt), 64'd0);
    chk("reset_wdog", 64'(sb_if.wdog_err), 64'd0);
    chk("reset_stall", 64'(sb_if.stall), 64'd0);
    chk("reset_sel", 64'(sb_if.fwd_sel), 64'd0);

    // basic stage-0 forward
    sb_if.stg_wen[0] = 1'b1; sb_if.stg_rd[0] = 5'd5;
    sb_if.stg_data[0] = 32'h1234; sb_if.stg_data_ok[0] = 1'b1;
    sb_if.rs_addr[0] = 5'd5;
    #2;
    chk("t1_sel", 64'(sb_if.fwd_sel), 64'b01);
    chk("t1_data0", 64'(sb_if.fwd_data[0]), 64'h1234);
    chk("t1_data1", 64'(sb_if.fwd_data[1]), 64'h0);
    chk("t1_stall", 64'(sb_if.stall), 64'd0);
    cyc();

    // youngest not-ready producer masks older ready one; port1 from stage 3
    idle();
    sb_if.stg_wen[0] = 1'b1; sb_if.stg_rd[0] = 5'd7; sb_if.stg_data_ok[0] = 1'b0;
    sb_if.stg_wen[2] = 1'b1; sb_if.stg_rd[2] = 5'd7;
    sb_if.stg_data[2] = 32'hAA; sb_if.stg_data_ok[2] = 1'b1;
    sb_if.stg_wen[1] = 1'b0; sb_if.stg_rd[1] = 5'd10;
    sb_if.stg_data[1] = 32'h1111; sb_if.stg_data_ok[1] = 1'b1;
    sb_if.stg_wen[3] = 1'b1; sb_if.stg_rd[3] = 5'd10;
    sb_if.stg_data[3] = 32'h3333; sb_if.stg_data_ok[3] = 1'b1;
    sb_if.rs_addr[0] = 5'd7; sb_if.rs_addr[1] = 5'd10;
    #2;
    chk("t2_stall", 64'(sb_if.stall), 64'd1);
    chk("t2_sel", 64'(sb_if.fwd_sel), 64'b10);
    chk("t2_data1", 64'(sb_if.fwd_data[1]), 64'h3333);
    cyc();
    chk("t2_stall_cnt", 64'(sb_if.stall_cnt), 64'd1);

    // reset pulse, then long op on x9
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t3_cnt_cleared", 64'(sb_if.stall_cnt), 64'd0);
    sb_if.issue_valid = 1'b1; sb_if.issue_long = 1'b1; sb_if.issue_rd = 5'd9;
    #2;
    chk("t3_issue_stall", 64'(sb_if.stall), 64'd0);
    cyc();
    idle();
    sb_if.rs_addr[0] = 5'd9;
    for (int k = 1; k <= 3; k++) begin
      #2;
      chk($sformatf("t3_raw_c%0d", k), 64'(sb_if.stall), 64'd1);
      cyc();
    end
    chk("t3_stall_cnt", 64'(sb_if.stall_cnt), 64'd3);
    sb_if.lc_valid = 1'b1; sb_if.lc_rd = 5'd9; sb_if.lc_data = 32'hBEEF;
    #2;
    chk("t3_lc_sel", 64'(sb_if.fwd_sel[0]), 64'd1);
    chk("t3_lc_data", 64'(sb_if.fwd_data[0]), 64'hBEEF);
    chk("t3_lc_stall", 64'(sb_if.stall), 64'd0);
    cyc();
    idle();
    sb_if.rs_addr[0] = 5'd9;
    #2;
    chk("t3_cleared_stall", 64'(sb_if.stall), 64'd0);
    chk("t3_cleared_sel", 64'(sb_if.fwd_sel[0]), 64'd0);
    chk("t3_cleared_data", 64'(sb_if.fwd_data[0]), 64'd0);
    chk("t3_cnt_hold", 64'(sb_if.stall_cnt), 64'd3);

    // busy x3, WAW, then set-wins-over-clear
    idle();
    sb_if.issue_valid = 1'b1; sb_if.issue_long = 1'b1; sb_if.issue_rd = 5'd3;
    cyc();
    idle();
    sb_if.issue_valid = 1'b1; sb_if.issue_rd = 5'd3;
    #2;
    chk("t4_waw_stall", 64'(sb_if.stall), 64'd1);
    cyc();
    idle();
    sb_if.issue_valid = 1'b1; sb_if.issue_long = 1'b1; sb_if.issue_rd = 5'd3;
    sb_if.lc_valid = 1'b1; sb_if.lc_rd = 5'd3; sb_if.lc_data = 32'h77;
    sb_if.rs_addr[1] = 5'd3;
    #2;
    chk("t4_setclr_stall", 64'(sb_if.stall), 64'd0);
    chk("t4_lc_sel1", 64'(sb_if.fwd_sel), 64'b10);
    chk("t4_lc_data1", 64'(sb_if.fwd_data[1]), 64'h77);
    cyc();
    idle();
    sb_if.rs_addr[0] = 5'd3;
    #2;
    chk("t4_still_busy", 64'(sb_if.stall), 64'd1);
    cyc();
    idle();
    sb_if.lc_valid = 1'b1; sb_if.lc_rd = 5'd3;
    cyc();
    idle();
    sb_if.lc_valid = 1'b1; sb_if.lc_rd = 5'd12; sb_if.lc_data = 32'h99;
    sb_if.rs_addr[0] = 5'd12; sb_if.rs_addr[1] = 5'd3;
    #2;
    chk("t4_idle_lc_stall", 64'(sb_if.stall), 64'd0);
    chk("t4_idle_lc_sel", 64'(sb_if.fwd_sel), 64'b00);
    chk("t4_idle_lc_data", 64'(sb_if.fwd_data[0]), 64'd0);
    cyc();
    chk("t4_stall_cnt", 64'(sb_if.stall_cnt), 64'd5);

    // x0 never forwarded, never busy
    idle();
    sb_if.stg_wen[0] = 1'b1; sb_if.stg_rd[0] = 5'd0;
    sb_if.stg_data[0] = 32'hDEAD; sb_if.stg_data_ok[0] = 1'b1;
    sb_if.issue_valid = 1'b1; sb_if.issue_long = 1'b1; sb_if.issue_rd = 5'd0;
    #2;
    chk("t5_sel", 64'(sb_if.fwd_sel), 64'b00);
    chk("t5_data0", 64'(sb_if.fwd_data[0]), 64'd0);
    chk("t5_stall", 64'(sb_if.stall), 64'd0);
    cyc();

    // long issue during a stall is not recorded
    idle();
    sb_if.stg_wen[0] = 1'b1; sb_if.stg_rd[0] = 5'd7; sb_if.stg_data_ok[0] = 1'b0;
    sb_if.rs_addr[0] = 5'd7;
    sb_if.issue_valid = 1'b1; sb_if.issue_long = 1'b1; sb_if.issue_rd = 5'd20;
    #2;
    chk("t6_load_use", 64'(sb_if.stall), 64'd1);
    cyc();
    idle();
    sb_if.rs_addr[0] = 5'd20;
    #2;
    chk("t6_not_busy", 64'(sb_if.stall), 64'd0);
    cyc();

    // watchdog: load-use held four cycles
    idle();
    sb_if.stg_wen[0] = 1'b1; sb_if.stg_rd[0] = 5'd7; sb_if.stg_data_ok[0] = 1'b0;
    sb_if.rs_addr[0] = 5'd7;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("t7_wdog_e%0d", k), 64'(sb_if.wdog_err), 64'(WD_EN && (k >= 4)));
    end
    idle();
    #2;
    chk("t7_clear_stall", 64'(sb_if.stall), 64'd0);
    cyc();
    chk("t7_wdog_sticky", 64'(sb_if.wdog_err), 64'(WD_EN));
    chk("t7_stall_cnt", 64'(sb_if.stall_cnt), 64'd10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t7_wdog_rst", 64'(sb_if.wdog_err), 64'd0);
    chk("t7_cnt_rst", 64'(sb_if.stall_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
